// File: rtl/counter_mod_updown_pkg.sv
// Shared constants and next-state helpers for the modulus up/down counter family.
// Helpers work on a fixed 32-bit word so one function serves every counter width.
package counter_mod_updown_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CNT_W_MAX = 32;

  typedef logic [CNT_W_MAX-1:0] cnt_word_t;

  // True when the next step in the given direction would cross a bound.
  function automatic logic at_terminal(input cnt_word_t count,
                                       input logic      up_down,
                                       input cnt_word_t max_val);
    logic hit;
    if (up_down == DIR_UP) hit = (count == max_val);
    else                   hit = (count == '0);
    return hit;
  endfunction

  function automatic cnt_word_t next_count(input cnt_word_t count,
                                           input logic      up_down,
                                           input logic      sat_mode,
                                           input cnt_word_t max_val);
    cnt_word_t nxt;
    nxt = count;
    if (up_down == DIR_DOWN) begin
      if (count != '0)                nxt = count - 1'b1;
      else if (sat_mode == MODE_WRAP) nxt = max_val;
    end else begin
      // Explicit compare against max_val keeps sub-power-of-two moduli from rolling naturally.
      if (count != max_val)           nxt = count + 1'b1;
      else if (sat_mode == MODE_WRAP) nxt = '0;
    end
    return nxt;
  endfunction

  function automatic cnt_word_t clamp_load(input cnt_word_t data,
                                           input cnt_word_t max_val);
    return (data > max_val) ? max_val : data;
  endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// Control/status bundle of one counter_mod_updown instance.
interface counter_mod_updown_if #(
  parameter int N = 9
);
  logic         CE;
  logic         clear;
  logic         load;
  logic [N-1:0] Data_in;
  logic         up_down;
  logic         sat_mode;
  logic [N-1:0] compare_value;
  logic         ovf_clr;
  logic [N-1:0] count;
  logic         match;
  logic         carry_out;
  logic         wrap_pulse;
  logic         ovf;

  modport master (
    output CE, clear, load, Data_in, up_down, sat_mode, compare_value, ovf_clr,
    input  count, match, carry_out, wrap_pulse, ovf
  );

  modport slave (
    input  CE, clear, load, Data_in, up_down, sat_mode, compare_value, ovf_clr,
    output count, match, carry_out, wrap_pulse, ovf
  );

endinterface

// File: rtl/counter_mod_updown.sv
// Loadable modulus counter with up/down, wrap/saturate, sync clear, compare match,
// cascade carry and a sticky overflow flag. Chain instances via carry_out -> CE.
module counter_mod_updown
  import counter_mod_updown_pkg::*;
#(
  parameter int N           = 9,
  parameter int MODULUS     = 2**N,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  counter_mod_updown_if.slave   bus
);

  if (N < 1 || N > 30) begin : g_bad_width
    $error("counter_mod_updown: N must be in 1..30");
  end
  if (MODULUS < 2 || MODULUS > 2**N) begin : g_bad_modulus
    $error("counter_mod_updown: MODULUS must be in 2..2**N");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("counter_mod_updown: RESET_VALUE must be below MODULUS");
  end

  localparam cnt_word_t    MAX_W   = cnt_word_t'(MODULUS - 1);
  localparam logic [N-1:0] RST_VAL = N'(RESET_VALUE);

  logic [N-1:0] count_q;
  logic         wrap_q;
  logic         ovf_q;
  cnt_word_t    count_w;
  logic         term;

  assign count_w = cnt_word_t'(count_q);
  assign term    = at_terminal(count_w, bus.up_down, MAX_W);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!bus.CE) begin
      wrap_q <= 1'b0;
      if (bus.ovf_clr) ovf_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= N'(clamp_load(cnt_word_t'(bus.Data_in), MAX_W));
      wrap_q  <= 1'b0;
      if (bus.ovf_clr) ovf_q <= 1'b0;
    end else begin
      count_q <= N'(next_count(count_w, bus.up_down, bus.sat_mode, MAX_W));
      wrap_q  <= term;
      // A bound event in the same cycle as ovf_clr keeps the flag set.
      ovf_q   <= term | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.count      = count_q;
  assign bus.match      = (count_q == bus.compare_value);
  assign bus.carry_out  = bus.CE & term & ~bus.load & ~bus.clear;
  assign bus.wrap_pulse = wrap_q;
  assign bus.ovf        = ovf_q;

endmodule
